// File: rtl/pll_mode_ctrl.sv
// -----------------------------------------------------------------------------
// pll_mode_ctrl
//   Sequences a PLL through reset, lock acquisition and run. It applies divider
//   settings from a per-mode table, retries timed-out lock attempts, and
//   reports loss of lock, invalid mode requests and retry exhaustion.
//
// Ports
//   I_clk          in   1  control clock
//   I_rst_n        in   1  asynchronous active-low reset
//   pll_lock       in   1  PLL LOCK (asynchronous to I_clk)
//   mode_req       in   2  requested mode index
//   mode_req_valid in   1  request strobe
//   mode_req_ready out  1  request can be accepted (RUN / FAIL)
//   pll_reset      out  1  drives PLL RESET
//   idsel          out  6  input divider for the current mode
//   mdsel          out  7  multiplier for the current mode
//   odsel0         out  7  pixel-clock divider for the current mode
//   odsel1         out  7  serial-clock divider for the current mode
//   mode_cur       out  2  applied mode index
//   clk_ok         out  1  PLL locked and stable
//   lock_lost      out  1  one-cycle pulse on loss of lock
//   mode_err       out  1  one-cycle pulse on an invalid request
//   fail           out  1  lock retries exhausted
// -----------------------------------------------------------------------------
module pll_mode_ctrl #(
  parameter int                       NUM_MODES     = 2,
  parameter int                       INIT_MODE     = 0,
  parameter logic [6*NUM_MODES-1:0]   IDIV_TABLE    = {6'd3, 6'd3},
  parameter logic [7*NUM_MODES-1:0]   MDIV_TABLE    = {7'd89, 7'd89},
  parameter logic [7*NUM_MODES-1:0]   ODIV0_TABLE   = {7'd20, 7'd10},
  parameter logic [7*NUM_MODES-1:0]   ODIV1_TABLE   = {7'd4, 7'd2},
  parameter int                       RST_CYCLES    = 16,
  parameter int                       STABLE_CYCLES = 1024,
  parameter int                       LOCK_TIMEOUT  = 65536,
  parameter int                       MAX_RETRY     = 3
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       pll_lock,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  output logic       mode_req_ready,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [6:0] mdsel,
  output logic [6:0] odsel0,
  output logic [6:0] odsel1,
  output logic [1:0] mode_cur,
  output logic       clk_ok,
  output logic       lock_lost,
  output logic       mode_err,
  output logic       fail
);

  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int YW = $clog2(MAX_RETRY) + 1;

  localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);
  localparam logic [YW-1:0] RETRY_MAX  = YW'(MAX_RETRY);
  localparam logic [2:0]    NUM_MODES3 = 3'(NUM_MODES);
  localparam logic [1:0]    INIT_M     = 2'(INIT_MODE);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAIL      = 2'd3
  } state_e;

  // Table lookups; callers only pass indices below NUM_MODES.
  function automatic logic [5:0] idiv_of(input logic [1:0] m);
    idiv_of = IDIV_TABLE[int'(m)*6 +: 6];
  endfunction

  function automatic logic [6:0] mdiv_of(input logic [1:0] m);
    mdiv_of = MDIV_TABLE[int'(m)*7 +: 7];
  endfunction

  function automatic logic [6:0] odiv0_of(input logic [1:0] m);
    odiv0_of = ODIV0_TABLE[int'(m)*7 +: 7];
  endfunction

  function automatic logic [6:0] odiv1_of(input logic [1:0] m);
    odiv1_of = ODIV1_TABLE[int'(m)*7 +: 7];
  endfunction

  state_e          state_q, state_d;
  logic            sync1_q, lock_s_q;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [YW-1:0]   retry_q, retry_d;
  logic [1:0]      mode_q, mode_d;
  logic [5:0]      idiv_q, idiv_d;
  logic [6:0]      mdiv_q, mdiv_d;
  logic [6:0]      odiv0_q, odiv0_d;
  logic [6:0]      odiv1_q, odiv1_d;
  logic            pll_reset_q, pll_reset_d;
  logic            clk_ok_q, clk_ok_d;
  logic            lock_lost_q, lock_lost_d;
  logic            mode_err_q, mode_err_d;
  logic            fail_q, fail_d;
  logic            ready_q, ready_d;

  logic            req_acc_s;
  logic            req_ok_s;
  logic [SW-1:0]   stable_inc_s;
  logic [TW-1:0]   tmo_inc_s;
  logic [YW-1:0]   retry_inc_s;

  assign req_acc_s = mode_req_valid & ready_q;
  assign req_ok_s  = ({1'b0, mode_req} < NUM_MODES3);

  // Saturating increments: counters hold at all-ones instead of wrapping.
  assign stable_inc_s = (stable_cnt_q == {SW{1'b1}}) ? stable_cnt_q : stable_cnt_q + SW'(1);
  assign tmo_inc_s    = (tmo_cnt_q == {TW{1'b1}}) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
  assign retry_inc_s  = (retry_q == {YW{1'b1}}) ? retry_q : retry_q + YW'(1);

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    stable_cnt_d = stable_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    retry_d      = retry_q;
    mode_d       = mode_q;
    idiv_d       = idiv_q;
    mdiv_d       = mdiv_q;
    odiv0_d      = odiv0_q;
    odiv1_d      = odiv1_q;
    lock_lost_d  = 1'b0;
    mode_err_d   = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          rst_cnt_d = (rst_cnt_q == {RW{1'b1}}) ? rst_cnt_q : rst_cnt_q + RW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        tmo_cnt_d    = tmo_inc_s;
        stable_cnt_d = lock_s_q ? stable_inc_s : {SW{1'b0}};
        // A completed stable window wins over a timeout on the same cycle.
        if (lock_s_q && (stable_inc_s == STABLE_MAX)) begin
          state_d = ST_RUN;
        end else if (tmo_inc_s == TMO_MAX) begin
          retry_d = retry_inc_s;
          if (retry_inc_s == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RESET;
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          lock_lost_d = 1'b1;
          retry_d     = {YW{1'b0}};
          state_d     = ST_RESET;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    // An accepted request overrides the lock-loss path, which still pulses.
    if (req_acc_s) begin
      if (req_ok_s) begin
        mode_d  = mode_req;
        idiv_d  = idiv_of(mode_req);
        mdiv_d  = mdiv_of(mode_req);
        odiv0_d = odiv0_of(mode_req);
        odiv1_d = odiv1_of(mode_req);
        retry_d = {YW{1'b0}};
        state_d = ST_RESET;
      end else begin
        mode_err_d = 1'b1;
      end
    end else begin
      mode_err_d = 1'b0;
    end

    // Every state is entered with fresh counters.
    if (state_d != state_q) begin
      rst_cnt_d    = {RW{1'b0}};
      stable_cnt_d = {SW{1'b0}};
      tmo_cnt_d    = {TW{1'b0}};
    end else begin
      rst_cnt_d    = rst_cnt_d;
    end

    pll_reset_d = (state_d == ST_RESET);
    clk_ok_d    = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
    ready_d     = (state_d == ST_RUN) || (state_d == ST_FAIL);
  end

  // State, counters, synchroniser and registered outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= ST_RESET;
      sync1_q      <= 1'b0;
      lock_s_q     <= 1'b0;
      rst_cnt_q    <= {RW{1'b0}};
      stable_cnt_q <= {SW{1'b0}};
      tmo_cnt_q    <= {TW{1'b0}};
      retry_q      <= {YW{1'b0}};
      mode_q       <= INIT_M;
      idiv_q       <= idiv_of(INIT_M);
      mdiv_q       <= mdiv_of(INIT_M);
      odiv0_q      <= odiv0_of(INIT_M);
      odiv1_q      <= odiv1_of(INIT_M);
      pll_reset_q  <= 1'b1;
      clk_ok_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
      mode_err_q   <= 1'b0;
      fail_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= pll_lock;
      lock_s_q     <= sync1_q;
      rst_cnt_q    <= rst_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      retry_q      <= retry_d;
      mode_q       <= mode_d;
      idiv_q       <= idiv_d;
      mdiv_q       <= mdiv_d;
      odiv0_q      <= odiv0_d;
      odiv1_q      <= odiv1_d;
      pll_reset_q  <= pll_reset_d;
      clk_ok_q     <= clk_ok_d;
      lock_lost_q  <= lock_lost_d;
      mode_err_q   <= mode_err_d;
      fail_q       <= fail_d;
      ready_q      <= ready_d;
    end
  end

  assign mode_req_ready = ready_q;
  assign pll_reset      = pll_reset_q;
  assign idsel          = idiv_q;
  assign mdsel          = mdiv_q;
  assign odsel0         = odiv0_q;
  assign odsel1         = odiv1_q;
  assign mode_cur       = mode_q;
  assign clk_ok         = clk_ok_q;
  assign lock_lost      = lock_lost_q;
  assign mode_err       = mode_err_q;
  assign fail           = fail_q;

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_mode_ctrl
//   Directed bench for pll_mode_ctrl with short timing parameters. Expected
//   values are hand-computed cycle counts relative to the clock edge at which
//   each stimulus is applied (2-flop lock synchroniser included).
// -----------------------------------------------------------------------------
module tb_pll_mode_ctrl;

  logic       I_clk;
  logic       I_rst_n;
  logic       pll_lock;
  logic [1:0] mode_req;
  logic       mode_req_valid;
  logic       mode_req_ready;
  logic       pll_reset;
  logic [5:0] idsel;
  logic [6:0] mdsel;
  logic [6:0] odsel0;
  logic [6:0] odsel1;
  logic [1:0] mode_cur;
  logic       clk_ok;
  logic       lock_lost;
  logic       mode_err;
  logic       fail;

  int n_checks = 0;
  int n_errors = 0;

  pll_mode_ctrl #(
    .RST_CYCLES    (4),
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (100),
    .MAX_RETRY     (2)
  ) dut (
    .I_clk          (I_clk),
    .I_rst_n        (I_rst_n),
    .pll_lock       (pll_lock),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready),
    .pll_reset      (pll_reset),
    .idsel          (idsel),
    .mdsel          (mdsel),
    .odsel0         (odsel0),
    .odsel1         (odsel1),
    .mode_cur       (mode_cur),
    .clk_ok         (clk_ok),
    .lock_lost      (lock_lost),
    .mode_err       (mode_err),
    .fail           (fail)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int pulses;
  int waited;

  initial begin
    I_rst_n        = 1'b0;
    pll_lock       = 1'b0;
    mode_req       = 2'd0;
    mode_req_valid = 1'b0;
    steps(2);

    // Reset state.
    check_eq("rst_pll_reset", 32'(pll_reset), 32'd1);
    check_eq("rst_mode_cur", 32'(mode_cur), 32'd0);
    check_eq("rst_idsel", 32'(idsel), 32'd3);
    check_eq("rst_mdsel", 32'(mdsel), 32'd89);
    check_eq("rst_odsel0", 32'(odsel0), 32'd10);
    check_eq("rst_odsel1", 32'(odsel1), 32'd2);
    check_eq("rst_clk_ok", 32'(clk_ok), 32'd0);
    check_eq("rst_ready", 32'(mode_req_ready), 32'd0);
    check_eq("rst_fail", 32'(fail), 32'd0);

    // Power-up: edges counted from reset release.
    I_rst_n = 1'b1;
    steps(3);                                   // after edge 3
    check_eq("pu_pll_reset_e3", 32'(pll_reset), 32'd1);
    step();                                     // edge 4
    check_eq("pu_pll_reset_e4", 32'(pll_reset), 32'd0);
    steps(6);                                   // edge 10
    pll_lock = 1'b1;
    steps(9);                                   // edge 19
    check_eq("pu_clk_ok_e19", 32'(clk_ok), 32'd0);
    step();                                     // edge 20
    check_eq("pu_clk_ok_e20", 32'(clk_ok), 32'd1);
    check_eq("pu_ready", 32'(mode_req_ready), 32'd1);
    check_eq("pu_mdsel", 32'(mdsel), 32'd89);
    check_eq("pu_odsel0", 32'(odsel0), 32'd10);

    // Mode switch to mode 1.
    mode_req       = 2'd1;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    check_eq("ms_odsel0", 32'(odsel0), 32'd20);
    check_eq("ms_odsel1", 32'(odsel1), 32'd4);
    check_eq("ms_mode_cur", 32'(mode_cur), 32'd1);
    check_eq("ms_pll_reset", 32'(pll_reset), 32'd1);
    check_eq("ms_clk_ok", 32'(clk_ok), 32'd0);
    check_eq("ms_ready", 32'(mode_req_ready), 32'd0);
    steps(3);
    check_eq("ms_pll_reset_4th", 32'(pll_reset), 32'd1);
    step();
    check_eq("ms_pll_reset_end", 32'(pll_reset), 32'd0);
    steps(7);
    check_eq("ms_clk_ok_early", 32'(clk_ok), 32'd0);
    step();
    check_eq("ms_clk_ok_relock", 32'(clk_ok), 32'd1);

    // Lock glitch of 3 cycles.
    pll_lock = 1'b0;
    steps(2);
    check_eq("gl_no_pulse_yet", 32'(lock_lost), 32'd0);
    step();
    check_eq("gl_lock_lost", 32'(lock_lost), 32'd1);
    check_eq("gl_clk_ok", 32'(clk_ok), 32'd0);
    check_eq("gl_pll_reset", 32'(pll_reset), 32'd1);
    pll_lock = 1'b1;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (lock_lost) pulses++;
    end
    check_eq("gl_extra_pulses", 32'(pulses), 32'd0);
    check_eq("gl_clk_ok_early", 32'(clk_ok), 32'd0);
    step();
    check_eq("gl_clk_ok_back", 32'(clk_ok), 32'd1);
    check_eq("gl_mode_cur", 32'(mode_cur), 32'd1);

    // Invalid request.
    mode_req       = 2'd3;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    check_eq("inv_mode_err", 32'(mode_err), 32'd1);
    check_eq("inv_mode_cur", 32'(mode_cur), 32'd1);
    check_eq("inv_odsel0", 32'(odsel0), 32'd20);
    check_eq("inv_clk_ok", 32'(clk_ok), 32'd1);
    check_eq("inv_pll_reset", 32'(pll_reset), 32'd0);
    step();
    check_eq("inv_mode_err_end", 32'(mode_err), 32'd0);
    check_eq("inv_clk_ok_hold", 32'(clk_ok), 32'd1);

    // Timeout: two 100-cycle attempts, then FAIL.
    pll_lock = 1'b0;
    steps(3);                                   // T+3: lock lost, RESET
    check_eq("to_lock_lost", 32'(lock_lost), 32'd1);
    steps(103);                                 // T+106: first WAIT_LOCK
    check_eq("to_wait1", 32'(pll_reset), 32'd0);
    step();                                     // T+107: retry into RESET
    check_eq("to_retry_reset", 32'(pll_reset), 32'd1);
    check_eq("to_retry_nofail", 32'(fail), 32'd0);
    steps(103);                                 // T+210
    check_eq("to_fail_early", 32'(fail), 32'd0);
    step();                                     // T+211
    check_eq("to_fail", 32'(fail), 32'd1);
    check_eq("to_fail_ready", 32'(mode_req_ready), 32'd1);
    check_eq("to_fail_pll_reset", 32'(pll_reset), 32'd0);
    check_eq("to_fail_clk_ok", 32'(clk_ok), 32'd0);

    // Mode 0 request from FAIL.
    mode_req       = 2'd0;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    check_eq("fr_fail_clear", 32'(fail), 32'd0);
    check_eq("fr_mode_cur", 32'(mode_cur), 32'd0);
    check_eq("fr_odsel0", 32'(odsel0), 32'd10);
    check_eq("fr_pll_reset", 32'(pll_reset), 32'd1);
    check_eq("fr_ready", 32'(mode_req_ready), 32'd0);

    // Lock stays low: wait (bounded) for FAIL again, then switch to mode 1.
    waited = 0;
    while (!fail && waited < 400) begin
      step();
      waited++;
    end
    check_eq("fr_refail", 32'(fail), 32'd1);
    mode_req       = 2'd1;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    steps(5);                                   // now in WAIT_LOCK
    check_eq("rw_mode_cur", 32'(mode_cur), 32'd1);
    check_eq("rw_pll_reset", 32'(pll_reset), 32'd0);

    // Asynchronous reset in WAIT_LOCK.
    #2;
    I_rst_n = 1'b0;
    #1;
    check_eq("ar_mode_cur", 32'(mode_cur), 32'd0);
    check_eq("ar_odsel0", 32'(odsel0), 32'd10);
    check_eq("ar_odsel1", 32'(odsel1), 32'd2);
    check_eq("ar_pll_reset", 32'(pll_reset), 32'd1);
    check_eq("ar_ready", 32'(mode_req_ready), 32'd0);
    check_eq("ar_fail", 32'(fail), 32'd0);
    steps(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_mode_ctrl.md
PLL_MODE_CTRL -- requirements
Module: pll_mode_ctrl

Interface
REQ-001 The block SHALL have one clock, I_clk, and one asynchronous, active-low reset, I_rst_n.
REQ-002 Parameter NUM_MODES, default 2: number of PLL mode table entries, range 1..4.
REQ-003 Parameter INIT_MODE, default 0: mode applied out of reset.
REQ-004 Parameter IDIV_TABLE, default {6'd3,6'd3}: packed 6-bit input divider per mode, with mode 0 in the LSBs.
REQ-005 Parameter MDIV_TABLE, default {7'd89,7'd89}: packed 7-bit multiplier per mode.
REQ-006 Parameter ODIV0_TABLE, default {7'd20,7'd10}: packed 7-bit pixel-clock divider per mode.
REQ-007 Parameter ODIV1_TABLE, default {7'd4,7'd2}: packed 7-bit serial-clock divider per mode.
REQ-008 Parameter RST_CYCLES, default 16: number of cycles pll_reset is held high.
REQ-009 Parameter STABLE_CYCLES, default 1024: number of consecutive synchronised-lock-high cycles required.
REQ-010 Parameter LOCK_TIMEOUT, default 65536: maximum cycles spent in WAIT_LOCK per attempt.
REQ-011 Parameter MAX_RETRY, default 3: number of timed-out attempts before entering FAIL.
REQ-012 Ports SHALL be:
- I_clk, in, 1: control clock.
- I_rst_n, in, 1: asynchronous active-low reset.
- pll_lock, in, 1: PLL LOCK, asynchronous to I_clk.
- mode_req, in, 2: requested mode index.
- mode_req_valid, in, 1: request strobe.
- mode_req_ready, out, 1: request can be accepted.
- pll_reset, out, 1: drives PLL RESET.
- idsel, out, 6: IDIV for the current mode.
- mdsel, out, 7: MDIV for the current mode.
- odsel0, out, 7: ODIV0 for the current mode.
- odsel1, out, 7: ODIV1 for the current mode.
- mode_cur, out, 2: applied mode index.
- clk_ok, out, 1: PLL locked and stable.
- lock_lost, out, 1: one-cycle pulse on loss of lock.
- mode_err, out, 1: one-cycle pulse on an invalid request.
- fail, out, 1: retries exhausted.

Function
REQ-013 pll_lock SHALL pass through a 2-flop synchroniser; all internal logic uses the synchronised signal lock_s.
REQ-014 The FSM SHALL have exactly four states: RESET, WAIT_LOCK, RUN and FAIL.
REQ-015 In RESET, pll_reset SHALL be 1 for exactly RST_CYCLES cycles; the FSM then moves to WAIT_LOCK and pll_reset goes to 0.
REQ-016 In WAIT_LOCK, the stable counter SHALL increment while lock_s=1 and clear to 0 when lock_s=0.
REQ-017 When the stable counter reaches STABLE_CYCLES, the FSM SHALL move to RUN and clk_ok SHALL be 1 from the first RUN cycle.
REQ-018 The WAIT_LOCK timeout counter SHALL count every cycle in WAIT_LOCK.
REQ-019 When the timeout counter reaches LOCK_TIMEOUT, the retry count SHALL increment and the FSM SHALL re-enter RESET with the same mode.
REQ-020 If the incremented retry count equals MAX_RETRY, the FSM SHALL enter FAIL instead, with fail=1 and pll_reset=0.
REQ-021 In RUN, lock_s=0 SHALL cause a lock_lost pulse the next cycle, clk_ok=0, retry count cleared, and re-entry to RESET with the same mode.
REQ-022 mode_req_ready SHALL be 1 only in RUN and FAIL.
REQ-023 A request SHALL be accepted when mode_req_valid=1 and mode_req_ready=1.
REQ-024 On an accepted valid request (mode_req<NUM_MODES), the next cycle SHALL show: mode_cur and all divider outputs updated from the tables, clk_ok=0, fail=0, retry count cleared, and state RESET; this applies even when mode_req equals mode_cur.
REQ-025 On an accepted request with mode_req>=NUM_MODES, mode_err SHALL pulse for one cycle and no other state or output SHALL change.
REQ-026 If an accepted request coincides with lock_s=0 in RUN, the request SHALL take priority and lock_lost SHALL still pulse.
REQ-027 Divider outputs SHALL change only on accepted valid requests or reset, and SHALL be registered.
REQ-028 Counters SHALL saturate and never wrap; the counter width is clog2 of the respective parameter plus 1.

Reset
REQ-029 While I_rst_n=0, outputs SHALL be: state RESET, pll_reset=1, mode_cur=INIT_MODE, dividers from the INIT_MODE table entry, clk_ok=0, fail=0, lock_lost=0, mode_err=0, mode_req_ready=0, and all counters and synchronisers 0.
REQ-030 Reset asserted mid-operation SHALL apply REQ-029 immediately (asynchronously).
REQ-031 After I_rst_n deasserts, the RESET-state count of REQ-015 SHALL start on the first I_clk edge.

Verification
Bench parameters: RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=100, MAX_RETRY=2.
REQ-032 Power-up lock: release reset and raise pll_lock at cycle 10 -> pll_reset high for cycles 1-4; clk_ok=1 at cycle 10+2+8; mdsel=89, odsel0=10.
REQ-033 Mode switch: in RUN, request mode 1 -> next cycle odsel0=20, odsel1=4, pll_reset=1 for 4 cycles, clk_ok=0 until relock; mode_cur=1.
REQ-034 Lock glitch: drop pll_lock for 3 cycles in RUN -> single lock_lost pulse, relock sequence, clk_ok returns after 8 stable cycles.
REQ-035 Timeout: hold pll_lock=0 -> two RESET/WAIT_LOCK attempts of 100 cycles each, then fail=1 and mode_req_ready=1; a mode 0 request clears fail and restarts the sequence.
REQ-036 Invalid request: mode_req=3 with NUM_MODES=2 -> mode_err pulse; mode_cur, dividers and clk_ok unchanged.
REQ-037 Reset in WAIT_LOCK after switching to mode 1 -> outputs return to mode 0 values immediately, per REQ-029.
